// File: rtl/cr_kme_fifo_arb_pkg.sv
// cr_kme_fifo_arb_pkg: shared defaults, state encoding and helpers for the KME FIFO arbiter.
package cr_kme_fifo_arb_pkg;
   localparam int N_REQ_DFLT  = 4;
   localparam int DATA_W_DFLT = 83;
   localparam int EOP_BIT     = DATA_W_DFLT - 1;
   localparam int STAT_W      = 16;
   typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;
   function automatic int eop_bit(input int data_w);
      return data_w - 1;
   endfunction
endpackage

// File: rtl/cr_kme_rr_pick.sv
// cr_kme_rr_pick: first set request at or after ptr (with wrap), as one-hot grant and index.
module cr_kme_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);
   always_comb begin
      idx = '0;
      any = |req;
      // Walk from the far end back so the nearest match to ptr is written last.
      for (int k = N - 1; k >= 0; k--)
         if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
      gnt = any ? (N'(1) << idx) : '0;
   end
endmodule

// File: rtl/cr_kme_fifo_arb.sv
// cr_kme_fifo_arb: round-robin, packet-locking arbiter feeding the KME staging FIFO write port.
// Optional per-requester beat counters via CR_KME_FIFO_ARB_STATS_EN.
module cr_kme_fifo_arb
   import cr_kme_fifo_arb_pkg::*;
#(
   parameter  int N_REQ  = N_REQ_DFLT,
   parameter  int DATA_W = DATA_W_DFLT,
   localparam int IW     = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ack,
   input  logic                    fifo_in_stall,
   input  logic                    fifo_overflow,
   output logic [DATA_W-1:0]       fifo_in,
   output logic                    fifo_in_valid,
   output logic [IW-1:0]           arb_owner,
   output logic                    arb_locked,
`ifdef CR_KME_FIFO_ARB_STATS_EN
   input  logic [IW-1:0]           stat_sel,
   input  logic                    stat_clr,
   output logic [STAT_W-1:0]       stat_cnt,
`endif
   output logic                    err_overflow
);
   localparam int EOP = eop_bit(DATA_W);

   arb_state_e        state, state_nxt;
   logic [IW-1:0]     rr_ptr, rr_ptr_nxt, owner_nxt, idx;
   logic [N_REQ-1:0]  elig, gnt;
   logic              any;
   logic [DATA_W-1:0] sel_data, last_q;

   // While locked only the owner may be picked, so the picker returns the owner or nothing.
   assign elig = (state == ARB_LOCK) ? (req_valid & (N_REQ'(1) << arb_owner)) : req_valid;

   cr_kme_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req (elig),
      .ptr (rr_ptr),
      .gnt (gnt),
      .idx (idx),
      .any (any)
   );

   assign sel_data      = req_data[idx*DATA_W +: DATA_W];
   assign fifo_in_valid = any & ~fifo_in_stall & rst_n;
   assign req_ack       = fifo_in_valid ? gnt : '0;
   assign fifo_in       = fifo_in_valid ? sel_data : last_q;
   assign arb_locked    = (state == ARB_LOCK);

   always_comb begin
      state_nxt  = state;
      owner_nxt  = arb_owner;
      rr_ptr_nxt = rr_ptr;
      if (fifo_in_valid) begin
         state_nxt  = sel_data[EOP] ? ARB_IDLE : ARB_LOCK;
         owner_nxt  = idx;
         rr_ptr_nxt = (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ARB_IDLE;
         rr_ptr       <= '0;
         arb_owner    <= '0;
         last_q       <= '0;
         err_overflow <= 1'b0;
      end else begin
         state        <= state_nxt;
         rr_ptr       <= rr_ptr_nxt;
         arb_owner    <= owner_nxt;
         last_q       <= fifo_in;
         err_overflow <= err_overflow | fifo_overflow;
      end
   end

`ifdef CR_KME_FIFO_ARB_STATS_EN
   logic [STAT_W-1:0] cnt [N_REQ];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
         stat_cnt <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++)
            if (stat_clr) cnt[i] <= '0;
            else if (req_ack[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
         stat_cnt <= (stat_clr || int'(stat_sel) >= N_REQ) ? '0 : cnt[stat_sel];
      end
   end
`endif
endmodule

// File: tb/tb_cr_kme_fifo_arb.sv
// tb_cr_kme_fifo_arb: randomized self-checking bench against a behavioural arbitration model.
module tb_cr_kme_fifo_arb;
   localparam int N  = 4;
   localparam int DW = 83;
   localparam int IW = 2;

   logic            clk = 0;
   logic            rst_n = 0;
   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ack;
   logic            fifo_in_stall = 0;
   logic            fifo_overflow = 0;
   logic [DW-1:0]   fifo_in;
   logic            fifo_in_valid;
   logic [IW-1:0]   arb_owner;
   logic            arb_locked;
   logic            err_overflow;
`ifdef CR_KME_FIFO_ARB_STATS_EN
   logic [IW-1:0]   stat_sel = '0;
   logic            stat_clr = 0;
   logic [15:0]     stat_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // reference model state
   logic          m_locked, m_err;
   int            m_owner, m_ptr;
   logic [DW-1:0] m_last;
   // expectations for the current cycle
   logic [N-1:0]  exp_ack;
   logic          exp_fv, exp_locked, exp_err;
   logic [DW-1:0] exp_fi;
   int            exp_owner;

   always #5 clk = ~clk;

   cr_kme_fifo_arb #(.N_REQ(N), .DATA_W(DW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ack       (req_ack),
      .fifo_in_stall (fifo_in_stall),
      .fifo_overflow (fifo_overflow),
      .fifo_in       (fifo_in),
      .fifo_in_valid (fifo_in_valid),
      .arb_owner     (arb_owner),
      .arb_locked    (arb_locked),
`ifdef CR_KME_FIFO_ARB_STATS_EN
      .stat_sel      (stat_sel),
      .stat_clr      (stat_clr),
      .stat_cnt      (stat_cnt),
`endif
      .err_overflow  (err_overflow)
   );

   function automatic logic [N*DW-1:0] mk(input logic [N-1:0] eops);
      logic [N*DW-1:0] d;
      for (int i = 0; i < N; i++) begin
         d[i*DW +: DW] = DW'({$urandom(), $urandom(), $urandom()});
         d[i*DW + DW - 1] = eops[i];
      end
      return d;
   endfunction

   task automatic model_reset();
      m_locked = 0; m_err = 0; m_owner = 0; m_ptr = 0; m_last = '0;
   endtask

   // Drive one cycle at the falling edge, predict outputs from the model, advance the model.
   task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic st, input logic ov);
      int g;
      @(negedge clk);
      req_valid = v; req_data = d; fifo_in_stall = st; fifo_overflow = ov;
      exp_locked = m_locked; exp_owner = m_owner; exp_err = m_err;
      g = -1;
      if (m_locked) begin
         if (v[m_owner]) g = m_owner;
      end else begin
         for (int k = 0; k < N; k++)
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      exp_ack = '0;
      exp_fv  = (g >= 0) && !st;
      exp_fi  = m_last;
      if (exp_fv) begin
         exp_ack[g] = 1'b1;
         exp_fi = d[g*DW +: DW];
         m_last = exp_fi;
         if (!m_locked || exp_fi[DW-1]) m_ptr = (g + 1) % N;
         if (exp_fi[DW-1]) m_locked = 0;
         else begin m_locked = 1; m_owner = g; end
      end
      m_err = m_err | ov;
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      rst_n = 0;
      req_valid = '1; req_data = mk('1);
      #1;
      checks++;
      if ({req_ack, fifo_in_valid} !== '0) begin
         errors++; $display("FAIL reset_grant: got ack=%b fv=%b exp 0", req_ack, fifo_in_valid);
      end
      checks++;
      if ({arb_locked, arb_owner, err_overflow} !== '0) begin
         errors++; $display("FAIL reset_state: got locked=%b owner=%0d err=%b exp 0", arb_locked, arb_owner, err_overflow);
      end
      checks++;
      if (fifo_in !== '0) begin
         errors++; $display("FAIL reset_fifo_in: got %h exp 0", fifo_in);
      end
      @(negedge clk);
      req_valid = '0;
      rst_n = 1;
   endtask

   task automatic test_rotation();
      for (int c = 0; c < 6; c++) begin
         step('1, mk('1), 0, 0);
         checks++;
         if (req_ack !== (N'(1) << (c % N)) || fifo_in_valid !== 1'b1 || fifo_in !== exp_fi) begin
            errors++; $display("FAIL rotation c%0d: got ack=%b fv=%b fi=%h exp ack=%b fv=1 fi=%h", c, req_ack, fifo_in_valid, fifo_in, N'(1) << (c % N), exp_fi);
         end
      end
   endtask

   task automatic test_packet_lock();
      logic [N-1:0] seq [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
      logic         lk  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [N-1:0] vv  [4] = '{4'b0011, 4'b0011, 4'b0011, 4'b0010};
      logic [N-1:0] ee  [4] = '{4'b0010, 4'b0010, 4'b0011, 4'b0010};
      for (int c = 0; c < 4; c++) begin
         step(vv[c], mk(ee[c]), 0, 0);
         checks++;
         if (req_ack !== seq[c] || req_ack !== exp_ack || arb_locked !== lk[c] || (lk[c] && arb_owner !== 0) || fifo_in !== exp_fi) begin
            errors++; $display("FAIL packet_lock c%0d: got ack=%b locked=%b owner=%0d exp ack=%b locked=%b owner=0", c, req_ack, arb_locked, arb_owner, seq[c], lk[c]);
         end
      end
   endtask

   task automatic test_stall();
      step(4'b0100, mk(4'b0000), 0, 0);
      checks++;
      if (req_ack !== 4'b0100) begin
         errors++; $display("FAIL stall_enter: got ack=%b exp 0100", req_ack);
      end
      for (int c = 0; c < 5; c++) begin
         step(4'b0100, mk(4'b1111), 1, 0);
         checks++;
         if (req_ack !== '0 || fifo_in_valid !== 1'b0 || arb_locked !== 1'b1 || arb_owner !== 2 || fifo_in !== exp_fi) begin
            errors++; $display("FAIL stall_hold c%0d: got ack=%b fv=%b locked=%b owner=%0d exp ack=0 fv=0 locked=1 owner=2", c, req_ack, fifo_in_valid, arb_locked, arb_owner);
         end
      end
      step(4'b0100, mk(4'b0100), 0, 0);
      checks++;
      if (req_ack !== 4'b0100 || fifo_in_valid !== 1'b1 || fifo_in !== exp_fi) begin
         errors++; $display("FAIL stall_release: got ack=%b fv=%b exp ack=0100 fv=1", req_ack, fifo_in_valid);
      end
   endtask

   task automatic test_owner_gap();
      step(4'b0010, mk(4'b0000), 0, 0);
      for (int c = 0; c < 3; c++) begin
         step(4'b1000, mk(4'b1111), 0, 0);
         checks++;
         if (req_ack !== '0 || arb_locked !== 1'b1 || arb_owner !== 1) begin
            errors++; $display("FAIL owner_gap c%0d: got ack=%b locked=%b owner=%0d exp ack=0 locked=1 owner=1", c, req_ack, arb_locked, arb_owner);
         end
      end
      step(4'b1010, mk(4'b1010), 0, 0);
      checks++;
      if (req_ack !== 4'b0010) begin
         errors++; $display("FAIL owner_gap_eop: got ack=%b exp 0010", req_ack);
      end
      step(4'b1000, mk(4'b1000), 0, 0);
      checks++;
      if (req_ack !== 4'b1000) begin
         errors++; $display("FAIL owner_gap_next: got ack=%b exp 1000", req_ack);
      end
   endtask

   task automatic test_error_reset();
      step('0, mk('0), 0, 1);
      for (int c = 0; c < 3; c++) begin
         step('0, mk('0), 0, 0);
         checks++;
         if (err_overflow !== 1'b1 || err_overflow !== exp_err) begin
            errors++; $display("FAIL err_sticky c%0d: got %b exp 1", c, err_overflow);
         end
      end
      step(4'b0001, mk(4'b0000), 0, 0);
      step(4'b0000, mk(4'b0000), 0, 0);
      checks++;
      if (arb_locked !== 1'b1) begin
         errors++; $display("FAIL err_lock: got locked=%b exp 1", arb_locked);
      end
      rst_n = 0;
      #1;
      checks++;
      if (arb_locked !== 1'b0 || err_overflow !== 1'b0 || fifo_in !== '0) begin
         errors++; $display("FAIL async_reset: got locked=%b err=%b fi=%h exp 0 0 0", arb_locked, err_overflow, fifo_in);
      end
      @(negedge clk);
      rst_n = 1;
      model_reset();
      step('1, mk('1), 0, 0);
      checks++;
      if (req_ack !== 4'b0001) begin
         errors++; $display("FAIL reset_ptr: got ack=%b exp 0001", req_ack);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         step(N'($urandom()), mk(N'($urandom() & $urandom())), ($urandom_range(3) == 0), ($urandom_range(63) == 0));
         checks++;
         if (req_ack !== exp_ack || fifo_in_valid !== exp_fv || fifo_in !== exp_fi || arb_locked !== exp_locked
             || (exp_locked && int'(arb_owner) != exp_owner) || err_overflow !== exp_err) begin
            errors++; $display("FAIL random c%0d: got ack=%b fv=%b locked=%b owner=%0d err=%b exp ack=%b fv=%b locked=%b owner=%0d err=%b",
                               c, req_ack, fifo_in_valid, arb_locked, arb_owner, err_overflow, exp_ack, exp_fv, exp_locked, exp_owner, exp_err);
         end
      end
   endtask

`ifdef CR_KME_FIFO_ARB_STATS_EN
   task automatic test_stats();
      @(negedge clk);
      stat_clr = 1; req_valid = '0; fifo_in_stall = 0;
      @(negedge clk);
      stat_clr = 0; stat_sel = 0;
      req_data = mk('1); req_valid = 4'b0001;
      repeat (70000) @(negedge clk);
      req_valid = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (stat_cnt !== 16'hFFFF) begin
         errors++; $display("FAIL stat_sat: got %h exp ffff", stat_cnt);
      end
      stat_clr = 1;
      @(negedge clk);
      stat_clr = 0;
      checks++;
      if (stat_cnt !== 16'h0000) begin
         errors++; $display("FAIL stat_clr: got %h exp 0000", stat_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_rotation();
      test_packet_lock();
      test_stall();
      test_owner_gap();
      test_error_reset();
      test_random();
`ifdef CR_KME_FIFO_ARB_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
